// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared constants, FSM state type and active-low segment
//            encodings for the multiplexed 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int       NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low encoding, bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_decoder
// Purpose  : Combinational 4-bit hex to active-low 7-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure table lookup; no state.
  always_comb begin
    seg = hex_to_seg(value);
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scanner
// Purpose  : Round-robin scan of eight digits over one shared cathode bus,
//            with a blanking interval at the start of every digit slot.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0] c_cnt_last   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] c_idx_last   = IW'(NUM_DIGITS - 1);

  scan_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [IW-1:0] r_idx,   w_idx_nxt;
  logic [3:0]    r_cap_nib, w_cap_nib_nxt;
  logic          r_cap_en,  w_cap_en_nxt;
  logic          r_cap_dp,  w_cap_dp_nxt;
  logic          w_frame_nxt;

  logic [6:0]    w_dec_seg;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_out_nxt;
  logic [7:0]    w_an_nxt;

  logic [6:0]    r_seg;
  logic          r_dp_out;
  logic [7:0]    r_an;
  logic          r_frame_start;

  // The decoder sees the value the holding register is about to take, so the
  // registered segment output is valid in the very first DRIVE cycle.
  hex_seg_decoder u_dec (
    .value (w_cap_nib_nxt),
    .seg   (w_dec_seg)
  );

  // State register: slot counter, digit index, FSM and captured digit data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= BLANK;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_cap_nib <= '0;
      r_cap_en  <= 1'b0;
      r_cap_dp  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_cap_nib <= w_cap_nib_nxt;
      r_cap_en  <= w_cap_en_nxt;
      r_cap_dp  <= w_cap_dp_nxt;
    end
  end

  // Next-state logic: capture at the end of blanking, advance digit at slot end.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_idx_nxt     = r_idx;
    w_cap_nib_nxt = r_cap_nib;
    w_cap_en_nxt  = r_cap_en;
    w_cap_dp_nxt  = r_cap_dp;
    w_frame_nxt   = 1'b0;
    case (r_state)
      BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt   = DRIVE;
          w_cap_nib_nxt = digits[{r_idx, 2'b00} +: 4];
          w_cap_en_nxt  = digit_en[r_idx];
          w_cap_dp_nxt  = dp[r_idx];
        end
      end
      default: begin
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 1'b1;
          w_frame_nxt = (r_idx == c_idx_last);
        end
      end
    endcase
  end

  // Output decode from the upcoming state; disabled digits stay dark.
  always_comb begin
    w_seg_nxt    = SEG_BLANK;
    w_dp_out_nxt = 1'b1;
    w_an_nxt     = AN_OFF;
    if (w_state_nxt == DRIVE && w_cap_en_nxt) begin
      w_seg_nxt    = w_dec_seg;
      w_dp_out_nxt = ~w_cap_dp_nxt;
      w_an_nxt     = ~(8'b1 << w_idx_nxt);
    end
  end

  // Output registers keep every output free of combinational input paths.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg         <= SEG_BLANK;
      r_dp_out      <= 1'b1;
      r_an          <= AN_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_seg_nxt;
      r_dp_out      <= w_dp_out_nxt;
      r_an          <= w_an_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

  assign seg         = r_seg;
  assign dp_out      = r_dp_out;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scanner
// Purpose  : Self-checking bench for seg_display_scanner with a cycle-level
//            reference model (slot = t / SCAN_DIV, phase = t % SCAN_DIV).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scanner;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [7:0]  dp;
  logic [6:0]  seg;
  logic        dp_out;
  logic [7:0]  an;
  logic        frame_start;

  seg_display_scanner #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .digit_en    (digit_en),
    .dp          (dp),
    .seg         (seg),
    .dp_out      (dp_out),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int t        = 0;
  int fs_seen  = 0;
  int fs_exp   = 0;

  logic [3:0] cap_nib [8];
  logic       cap_en  [8];
  logic       cap_dp  [8];

  // Lit segments of each hex glyph, as letters a..g.
  string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                      "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                      "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] s;
    string      g;
    int         p;
    s = 7'h7F;
    g = lit[v];
    for (int k = 0; k < g.len(); k++) begin
      p = int'(g[k]) - 97;
      s[3'(p)] = 1'b0;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Check the current cycle against the model, record captures, advance.
  task automatic step();
    int         phase;
    int         slot;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    phase = t % SD;
    slot  = (t / SD) % 8;
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (phase >= BL && cap_en[slot]) begin
      e_an  = ~(8'b1 << slot);
      e_seg = ref_seg(cap_nib[slot]);
      e_dp  = ~cap_dp[slot];
    end
    e_fs = (t > 0) && (t % FRAME == 0);
    check("an", {24'd0, an}, {24'd0, e_an});
    check("seg", {25'd0, seg}, {25'd0, e_seg});
    check("dp_out", {31'd0, dp_out}, {31'd0, e_dp});
    check("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    check("one_anode", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    if (frame_start === 1'b1) fs_seen++;
    if (e_fs) fs_exp++;
    if (phase == BL - 1) begin
      cap_nib[slot] = digits[slot*4 +: 4];
      cap_en[slot]  = digit_en[slot];
      cap_dp[slot]  = dp[slot];
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  // Hold reset for n edges checking the dark state, then release (cycle 0).
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_an", {24'd0, an}, 32'hFF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_dp", {31'd0, dp_out}, 32'd1);
      check("rst_fs", {31'd0, frame_start}, 32'd0);
    end
    rst = 1'b0;
    t   = 0;
  endtask

  initial begin
    int fs_before;
    rst      = 1'b1;
    digits   = 32'h0;
    digit_en = 8'h00;
    dp       = 8'h00;
    do_reset(3);

    // Full scan plus index wrap over three frames.
    digits   = 32'h76543210;
    digit_en = 8'hFF;
    dp       = 8'h00;
    fs_before = fs_seen;
    for (int i = 0; i < 3 * FRAME + 1; i++) step();
    check("three_frames", fs_seen - fs_before, 32'd3);

    // Reset in the middle of digit 5's DRIVE phase.
    while (t % FRAME != 5 * SD + 4) step();
    do_reset(3);

    // Enable mask: only digits 0 and 2 light.
    digits   = $urandom;
    digit_en = 8'b0000_0101;
    dp       = $urandom;
    for (int i = 0; i < FRAME; i++) step();

    // Decimal point on digit 1 with a hex letter.
    digits   = 32'h000000A0;
    digit_en = 8'hFF;
    dp       = 8'h02;
    for (int i = 0; i < FRAME; i++) step();

    // Mid-slot change of digit 3 must wait for the next frame.
    dp     = 8'h00;
    digits = 32'h00001000;
    while (t % FRAME != 3 * SD + 4) step();
    digits = 32'h0000F000;
    for (int i = 0; i < FRAME; i++) step();

    // Random inputs changing every cycle.
    for (int i = 0; i < 5 * FRAME; i++) begin
      digits   = $urandom;
      digit_en = 8'($urandom);
      dp       = 8'($urandom);
      step();
    end

    check("fs_total", fs_seen, fs_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
